// File: rtl/core_bus_arb_pkg.sv
// Shared constants for the core bus arbiter: FSM encoding and default bus geometry.
package core_bus_arb_pkg;

    localparam int MASTER_NUM_DEF = 3;
    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int CNT_W          = 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REQ      = 2'd1;
    localparam logic [1:0] ST_WAIT_RSP = 2'd2;

endpackage

// File: rtl/core_bus_arb_arb_pick.sv
// Combinational one-hot picker: fixed priority (index 0 first) or round-robin from ptr_i.
module core_bus_arb_arb_pick #(
    parameter int N       = 3,
    parameter int RR_MODE = 1,
    parameter int PW      = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          vld_o
);

    localparam int CW = PW + 1;

    logic [CW-1:0] cand;

    // Walk N candidates starting at the pointer, wrapping modulo N; first hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = (RR_MODE != 0) ? ({1'b0, ptr_i} + CW'(i)) : CW'(i);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!vld_o && req_i[cand[PW-1:0]]) begin
                gnt_o[cand[PW-1:0]] = 1'b1;
                idx_o               = cand[PW-1:0];
                vld_o               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_bus_arb.sv
// N-master to 1-slave bus arbiter: one outstanding transaction, read timeout.
module core_bus_arb
    import core_bus_arb_pkg::*;
#(
    parameter int MASTER_NUM = MASTER_NUM_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RR_MODE    = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MASTER_NUM-1:0]        m_req_i,
    input  logic [MASTER_NUM-1:0]        m_we_i,
    input  logic [MASTER_NUM*ADDR_W-1:0] m_addr_i,
    input  logic [MASTER_NUM*DATA_W-1:0] m_wdata_i,
    output logic [MASTER_NUM-1:0]        m_gnt_o,
    output logic [MASTER_NUM-1:0]        m_rvalid_o,
    output logic [DATA_W-1:0]            m_rdata_o,
    output logic                         m_err_o,
    output logic                         s_req_o,
    output logic                         s_we_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W-1:0]            s_wdata_o,
    input  logic                         s_gnt_i,
    input  logic                         s_rvalid_i,
    input  logic [DATA_W-1:0]            s_rdata_i,
    output logic                         busy_o
);

    localparam int PW = $clog2(MASTER_NUM);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [PW-1:0]         rr_q, rr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [MASTER_NUM-1:0] rvalid_q, rvalid_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  latch;

    logic [MASTER_NUM-1:0] pick_gnt;
    logic [PW-1:0]         pick_idx;
    logic                  pick_vld;

    function automatic logic [MASTER_NUM-1:0] onehot(input logic [PW-1:0] k);
        onehot    = '0;
        onehot[k] = 1'b1;
    endfunction

    core_bus_arb_arb_pick #(
        .N       (MASTER_NUM),
        .RR_MODE (RR_MODE),
        .PW      (PW)
    ) u_pick (
        .req_i (m_req_i),
        .ptr_i (rr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        latch    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    latch   = 1'b1;
                    owner_d = pick_idx;
                    rr_d    = (pick_idx == PW'(MASTER_NUM - 1)) ? '0 : pick_idx + 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (s_gnt_i) begin
                    cnt_d   = '0;
                    state_d = we_q ? ST_IDLE : ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (s_rvalid_i) begin
                    rvalid_d = onehot(owner_q);
                    rdata_d  = s_rdata_i;
                    state_d  = ST_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    // Timed-out read completes with zero data and an error flag.
                    rvalid_d = onehot(owner_q);
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Payload registers carry no reset; the slave outputs are masked outside REQ.
    always_ff @(posedge clk) begin
        if (latch) begin
            we_q    <= m_we_i[pick_idx];
            addr_q  <= m_addr_i[pick_idx*ADDR_W +: ADDR_W];
            wdata_q <= m_wdata_i[pick_idx*DATA_W +: DATA_W];
        end
    end

    assign s_req_o    = (state_q == ST_REQ);
    assign s_we_o     = s_req_o & we_q;
    assign s_addr_o   = s_req_o ? addr_q : '0;
    assign s_wdata_o  = s_req_o ? wdata_q : '0;
    assign m_gnt_o    = (s_req_o && s_gnt_i && !rst) ? onehot(owner_q) : '0;
    assign m_rvalid_o = rvalid_q;
    assign m_rdata_o  = rdata_q;
    assign m_err_o    = err_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_core_bus_arb.sv
// Bench for core_bus_arb: directed scenarios plus randomized transactions against a reference model.
module tb_core_bus_arb;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NM-1:0]    m_req, m_we, m_gnt, m_rvalid;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [DW-1:0]    m_rdata, s_wdata, s_rdata;
    logic [AW-1:0]    s_addr;
    logic             m_err, s_req, s_we, s_gnt, s_rvalid, busy;

    logic [NM-1:0]    f_req, f_we, f_gnt, f_rvalid;
    logic [NM*AW-1:0] f_addr;
    logic [NM*DW-1:0] f_wdata;
    logic [DW-1:0]    f_rdata, f_swdata, f_srdata;
    logic [AW-1:0]    f_saddr;
    logic             f_err, f_sreq, f_swe, f_sgnt, f_srvalid, f_busy;

    int n_chk  = 0;
    int n_pass = 0;
    int mdl_ptr = 0;

    core_bus_arb #(.MASTER_NUM(NM), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(16)) dut_rr (
        .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
        .m_wdata_i(m_wdata), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
        .m_err_o(m_err), .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr),
        .s_wdata_o(s_wdata), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .busy_o(busy)
    );

    core_bus_arb #(.MASTER_NUM(NM), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(16)) dut_fx (
        .clk(clk), .rst(rst), .m_req_i(f_req), .m_we_i(f_we), .m_addr_i(f_addr),
        .m_wdata_i(f_wdata), .m_gnt_o(f_gnt), .m_rvalid_o(f_rvalid), .m_rdata_o(f_rdata),
        .m_err_o(f_err), .s_req_o(f_sreq), .s_we_o(f_swe), .s_addr_o(f_saddr),
        .s_wdata_o(f_swdata), .s_gnt_i(f_sgnt), .s_rvalid_i(f_srvalid), .s_rdata_i(f_srdata),
        .busy_o(f_busy)
    );

    // Reference arbitration: scan from the pointer (or from 0) modulo NM.
    function automatic int model_pick(input logic [NM-1:0] mask, input bit rr, input int ptr);
        for (int i = 0; i < NM; i++) begin
            int k;
            k = rr ? (ptr + i) % NM : i;
            if (mask[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [NM-1:0] oh(input int k);
        logic [NM-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_chk++; if ({busy, s_req, s_we, m_gnt, m_rvalid, m_err} !== '0)
            $display("FAIL reset_ctrl: got %b exp 0", {busy, s_req, s_we, m_gnt, m_rvalid, m_err}); else n_pass++;
        n_chk++; if ({m_rdata, s_addr, s_wdata} !== '0)
            $display("FAIL reset_data: got %h exp 0", {m_rdata, s_addr, s_wdata}); else n_pass++;
        n_chk++; if ({f_busy, f_sreq, f_swe, f_gnt, f_rvalid, f_err, f_rdata, f_saddr, f_swdata} !== '0)
            $display("FAIL reset_fixed: got %h exp 0", {f_busy, f_sreq, f_swe, f_gnt, f_rvalid, f_err, f_rdata, f_saddr, f_swdata}); else n_pass++;
        rst = 1'b0;
        mdl_ptr = 0;
    endtask

    task automatic test_write;
        int w;
        m_req = 3'b010; m_we = 3'b010;
        m_addr[1*AW +: AW] = 32'h100; m_wdata[1*DW +: DW] = 32'hDEADBEEF;
        s_gnt = 1'b1;
        w = model_pick(m_req, 1'b1, mdl_ptr);
        tick;
        n_chk++; if ({s_req, s_we} !== 2'b11) $display("FAIL wr_sreq: got %b exp 11", {s_req, s_we}); else n_pass++;
        n_chk++; if (s_addr !== 32'h100) $display("FAIL wr_addr: got %h exp 100", s_addr); else n_pass++;
        n_chk++; if (s_wdata !== 32'hDEADBEEF) $display("FAIL wr_wdata: got %h exp deadbeef", s_wdata); else n_pass++;
        n_chk++; if (m_gnt !== oh(w)) $display("FAIL wr_gnt: got %b exp %b", m_gnt, oh(w)); else n_pass++;
        m_req = '0;
        mdl_ptr = (w + 1) % NM;
        tick;
        n_chk++; if ({busy, m_gnt} !== '0) $display("FAIL wr_idle: got %b exp 0", {busy, m_gnt}); else n_pass++;
        s_gnt = 1'b0;
    endtask

    task automatic test_read;
        int w;
        m_req = 3'b001; m_we = 3'b000; m_addr[0 +: AW] = 32'h40; s_gnt = 1'b1;
        w = model_pick(m_req, 1'b1, mdl_ptr);
        tick;
        n_chk++; if ({s_req, s_we, s_addr} !== {2'b10, 32'h40}) $display("FAIL rd_req: got %h exp %h", {s_req, s_we, s_addr}, {2'b10, 32'h40}); else n_pass++;
        n_chk++; if (m_gnt !== oh(w)) $display("FAIL rd_gnt: got %b exp %b", m_gnt, oh(w)); else n_pass++;
        m_req = '0;
        mdl_ptr = (w + 1) % NM;
        tick;
        s_gnt = 1'b0;
        tick;
        tick;
        n_chk++; if ({busy, m_rvalid} !== 4'b1000) $display("FAIL rd_wait: got %b exp 1000", {busy, m_rvalid}); else n_pass++;
        s_rvalid = 1'b1; s_rdata = 32'h12345678;
        tick;
        s_rvalid = 1'b0;
        n_chk++; if (m_rvalid !== 3'b001) $display("FAIL rd_rvalid: got %b exp 001", m_rvalid); else n_pass++;
        n_chk++; if (m_rdata !== 32'h12345678) $display("FAIL rd_rdata: got %h exp 12345678", m_rdata); else n_pass++;
        n_chk++; if ({m_err, busy} !== 2'b00) $display("FAIL rd_err_busy: got %b exp 00", {m_err, busy}); else n_pass++;
        tick;
        n_chk++; if (m_rvalid !== '0) $display("FAIL rd_pulse: got %b exp 000", m_rvalid); else n_pass++;
    endtask

    task automatic test_timeout;
        int w;
        m_req = 3'b100; m_we = 3'b000; m_addr[2*AW +: AW] = 32'h800; s_gnt = 1'b1;
        w = model_pick(m_req, 1'b1, mdl_ptr);
        tick;
        n_chk++; if (m_gnt !== oh(w)) $display("FAIL to_gnt: got %b exp %b", m_gnt, oh(w)); else n_pass++;
        m_req = '0;
        mdl_ptr = (w + 1) % NM;
        tick;
        s_gnt = 1'b0;
        for (int k = 1; k < 16; k++) begin
            tick;
            n_chk++; if ({m_rvalid, m_err, busy} !== 5'b00001)
                $display("FAIL to_wait_%0d: got %b exp 00001", k, {m_rvalid, m_err, busy}); else n_pass++;
        end
        tick;
        n_chk++; if ({m_rvalid, m_err, busy} !== {oh(w), 2'b10})
            $display("FAIL to_fire: got %b exp %b", {m_rvalid, m_err, busy}, {oh(w), 2'b10}); else n_pass++;
        n_chk++; if (m_rdata !== '0) $display("FAIL to_rdata: got %h exp 0", m_rdata); else n_pass++;
        s_rvalid = 1'b1; s_rdata = $urandom;
        for (int k = 0; k < 2; k++) begin
            tick;
            n_chk++; if ({m_rvalid, m_err, busy} !== '0)
                $display("FAIL to_late_%0d: got %b exp 0", k, {m_rvalid, m_err, busy}); else n_pass++;
        end
        s_rvalid = 1'b0;
    endtask

    task automatic test_rr_fair;
        int w;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        mdl_ptr = 0;
        m_req = 3'b111; m_we = 3'b111; s_gnt = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (c % 2 == 0) begin
                w = model_pick(m_req, 1'b1, mdl_ptr);
                mdl_ptr = (w + 1) % NM;
                n_chk++; if (m_gnt !== oh(w)) $display("FAIL rr_gnt_%0d: got %b exp %b", c / 2, m_gnt, oh(w)); else n_pass++;
            end else begin
                n_chk++; if ({m_gnt, busy} !== '0) $display("FAIL rr_idle_%0d: got %b exp 0", c / 2, {m_gnt, busy}); else n_pass++;
            end
        end
        m_req = '0;
        s_gnt = 1'b0;
        tick;
    endtask

    task automatic test_fixed;
        int w;
        f_req = 3'b111; f_we = 3'b111; f_sgnt = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (c % 2 == 0) begin
                w = model_pick(f_req, 1'b0, 0);
                n_chk++; if (f_gnt !== oh(w)) $display("FAIL fx_gnt_%0d: got %b exp %b", c / 2, f_gnt, oh(w)); else n_pass++;
            end else begin
                n_chk++; if ({f_gnt, f_busy} !== '0) $display("FAIL fx_idle_%0d: got %b exp 0", c / 2, {f_gnt, f_busy}); else n_pass++;
            end
        end
        f_req = '0;
        f_sgnt = 1'b0;
        tick;
    endtask

    task automatic test_backpressure;
        int w;
        logic [AW-1:0] a;
        a = $urandom;
        m_req = 3'b100; m_we = 3'b100; m_addr[2*AW +: AW] = a; s_gnt = 1'b0;
        w = model_pick(m_req, 1'b1, mdl_ptr);
        tick;
        m_req = '0;
        for (int c = 0; c < 5; c++) begin
            n_chk++; if ({s_req, s_addr, m_gnt} !== {1'b1, a, 3'b000})
                $display("FAIL bp_hold_%0d: got %h exp %h", c, {s_req, s_addr, m_gnt}, {1'b1, a, 3'b000}); else n_pass++;
            tick;
        end
        s_gnt = 1'b1;
        #1;
        n_chk++; if (m_gnt !== oh(w)) $display("FAIL bp_gnt: got %b exp %b", m_gnt, oh(w)); else n_pass++;
        mdl_ptr = (w + 1) % NM;
        tick;
        s_gnt = 1'b0;
        n_chk++; if ({m_gnt, s_req, busy} !== '0) $display("FAIL bp_after: got %b exp 0", {m_gnt, s_req, busy}); else n_pass++;
    endtask

    task automatic test_random;
        int w, d, lat;
        logic [AW-1:0] a [NM];
        logic [DW-1:0] wd [NM];
        logic [DW-1:0] rd;
        for (int t = 0; t < 40; t++) begin
            m_req = NM'($urandom_range(1, (1 << NM) - 1));
            m_we  = NM'($urandom);
            for (int k = 0; k < NM; k++) begin
                a[k] = $urandom; wd[k] = $urandom;
                m_addr[k*AW +: AW] = a[k]; m_wdata[k*DW +: DW] = wd[k];
            end
            w = model_pick(m_req, 1'b1, mdl_ptr);
            tick;
            n_chk++; if ({s_req, s_we, s_addr, s_wdata, m_gnt} !== {1'b1, m_we[w], a[w], wd[w], 3'b000})
                $display("FAIL rnd_req_%0d: got %h exp %h", t, {s_req, s_we, s_addr, s_wdata, m_gnt}, {1'b1, m_we[w], a[w], wd[w], 3'b000}); else n_pass++;
            d = $urandom_range(0, 2);
            for (int c = 0; c < d; c++) tick;
            s_gnt = 1'b1;
            #1;
            n_chk++; if (m_gnt !== oh(w)) $display("FAIL rnd_gnt_%0d: got %b exp %b", t, m_gnt, oh(w)); else n_pass++;
            mdl_ptr = (w + 1) % NM;
            tick;
            s_gnt = 1'b0;
            m_req = '0;
            if (!m_we[w]) begin
                lat = $urandom_range(0, 4);
                for (int c = 0; c < lat; c++) tick;
                rd = $urandom;
                s_rvalid = 1'b1; s_rdata = rd;
                tick;
                s_rvalid = 1'b0;
                n_chk++; if ({m_rvalid, m_rdata, m_err} !== {oh(w), rd, 1'b0})
                    $display("FAIL rnd_rsp_%0d: got %h exp %h", t, {m_rvalid, m_rdata, m_err}, {oh(w), rd, 1'b0}); else n_pass++;
            end
            n_chk++; if (busy !== 1'b0) $display("FAIL rnd_busy_%0d: got %b exp 0", t, busy); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_read;
        int w;
        m_req = 3'b001; m_we = 3'b000; s_gnt = 1'b1;
        w = model_pick(m_req, 1'b1, mdl_ptr);
        tick;
        m_req = '0;
        mdl_ptr = (w + 1) % NM;
        tick;
        s_gnt = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        mdl_ptr = 0;
        n_chk++; if ({busy, s_req, s_we, m_gnt, m_rvalid, m_err, m_rdata, s_addr, s_wdata} !== '0)
            $display("FAIL rst_mid: got %h exp 0", {busy, s_req, s_we, m_gnt, m_rvalid, m_err, m_rdata, s_addr, s_wdata}); else n_pass++;
        s_rvalid = 1'b1; s_rdata = 32'hCAFEF00D;
        tick;
        s_rvalid = 1'b0;
        n_chk++; if ({m_rvalid, m_err} !== '0) $display("FAIL rst_stale: got %b exp 0", {m_rvalid, m_err}); else n_pass++;
        m_req = 3'b111; m_we = 3'b111; s_gnt = 1'b1;
        w = model_pick(m_req, 1'b1, mdl_ptr);
        tick;
        n_chk++; if (m_gnt !== oh(w)) $display("FAIL rst_ptr: got %b exp %b", m_gnt, oh(w)); else n_pass++;
        m_req = '0;
        tick;
        s_gnt = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        f_req = '0; f_we = '0; f_addr = '0; f_wdata = '0;
        f_sgnt = 1'b0; f_srvalid = 1'b0; f_srdata = '0;
        test_reset;
        test_write;
        test_read;
        test_timeout;
        test_rr_fair;
        test_fixed;
        test_backpressure;
        test_random;
        test_reset_mid_read;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
